// File: rtl/vector_sweep_ctrl.sv
// Exhaustive stimulus sequencer: steps vec_out through every input pattern, waits a
// settle time, then hands each (vector, response) record to a logger via valid/ready.
module vector_sweep_ctrl #(
    parameter int N_IN   = 6,
    parameter int N_OUT  = 1,
    parameter int SETTLE = 1
) (
    input  logic              CK,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic [N_IN-1:0]   vec_out,
    input  logic [N_OUT-1:0]  dut_out,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [N_IN-1:0]   rec_vec,
    output logic [N_OUT-1:0]  rec_resp,
    output logic              busy,
    output logic              done,
    output logic [N_IN:0]     resp_ones
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_EMIT,
        ST_DONE
    } state_t;

    localparam logic [7:0]      SETTLE_INIT = 8'(SETTLE - 1);
    localparam logic [N_IN-1:0] VEC_LAST    = '1;
    localparam logic [N_IN-1:0] VEC_ONE     = 1;
    localparam logic [N_IN:0]   ONES_ONE    = 1;

    state_t            state, state_n;
    logic [7:0]        cnt, cnt_n;
    logic [N_IN-1:0]   vec_n, rec_vec_n;
    logic [N_OUT-1:0]  rec_resp_n;
    logic              rec_valid_n;
    logic [N_IN:0]     resp_ones_n;

    always_ff @(posedge CK) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            vec_out   <= '0;
            rec_valid <= 1'b0;
            rec_vec   <= '0;
            rec_resp  <= '0;
            resp_ones <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            vec_out   <= vec_n;
            rec_valid <= rec_valid_n;
            rec_vec   <= rec_vec_n;
            rec_resp  <= rec_resp_n;
            resp_ones <= resp_ones_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        vec_n       = vec_out;
        rec_valid_n = rec_valid;
        rec_vec_n   = rec_vec;
        rec_resp_n  = rec_resp;
        resp_ones_n = resp_ones;
        busy        = 1'b0;
        done        = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    vec_n       = '0;
                    cnt_n       = SETTLE_INIT;
                    resp_ones_n = '0;
                    state_n     = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                busy = 1'b1;
                if (abort) begin
                    rec_valid_n = 1'b0;
                    vec_n       = '0;
                    state_n     = ST_IDLE;
                end else if (cnt == 8'd0) begin
                    rec_resp_n  = dut_out;
                    rec_vec_n   = vec_out;
                    rec_valid_n = 1'b1;
                    state_n     = ST_EMIT;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end

            ST_EMIT: begin
                busy = 1'b1;
                // An accepted record is still counted when abort lands on the same edge.
                if (rec_valid && rec_ready) begin
                    rec_valid_n = 1'b0;
                    if (rec_resp != '0) begin
                        resp_ones_n = resp_ones + ONES_ONE;
                    end
                    if (vec_out == VEC_LAST) begin
                        state_n = ST_DONE;
                    end else begin
                        vec_n   = vec_out + VEC_ONE;
                        cnt_n   = SETTLE_INIT;
                        state_n = ST_SETTLE;
                    end
                end
                if (abort) begin
                    rec_valid_n = 1'b0;
                    vec_n       = '0;
                    state_n     = ST_IDLE;
                end
            end

            ST_DONE: begin
                done    = 1'b1;
                state_n = ST_IDLE;
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_vector_sweep_ctrl.sv
// Scoreboard bench for vector_sweep_ctrl: a parity DUT on a SETTLE=1 instance and a
// two-cycle-latency registered DUT on a SETTLE=3 instance.
module tb_vector_sweep_ctrl;

    localparam int NVEC = 64;

    typedef struct packed {
        logic [5:0] v;
        logic [0:0] r;
    } rec_t;

    logic CK = 1'b0;
    always #5 CK = ~CK;

    logic reset;
    int   cyc = 0;
    always @(posedge CK) cyc <= cyc + 1;

    logic       start_a, abort_a, rec_ready_a;
    logic [5:0] vec_out_a, rec_vec_a;
    logic [0:0] dut_out_a, rec_resp_a;
    logic       rec_valid_a, busy_a, done_a;
    logic [6:0] resp_ones_a;

    logic       start_b, abort_b, rec_ready_b;
    logic [5:0] vec_out_b, rec_vec_b;
    logic [0:0] dut_out_b, rec_resp_b;
    logic       rec_valid_b, busy_b, done_b;
    logic [6:0] resp_ones_b;
    logic       lat1, lat2;

    assign dut_out_a = ^vec_out_a;

    // Registered DUT model: bit 0 of the vector appears two cycles later.
    always @(posedge CK) begin
        lat1 <= vec_out_b[0];
        lat2 <= lat1;
    end
    assign dut_out_b = lat2;

    vector_sweep_ctrl #(.N_IN(6), .N_OUT(1), .SETTLE(1)) dut_a (
        .CK(CK), .reset(reset), .start(start_a), .abort(abort_a),
        .vec_out(vec_out_a), .dut_out(dut_out_a),
        .rec_valid(rec_valid_a), .rec_ready(rec_ready_a),
        .rec_vec(rec_vec_a), .rec_resp(rec_resp_a),
        .busy(busy_a), .done(done_a), .resp_ones(resp_ones_a)
    );

    vector_sweep_ctrl #(.N_IN(6), .N_OUT(1), .SETTLE(3)) dut_b (
        .CK(CK), .reset(reset), .start(start_b), .abort(abort_b),
        .vec_out(vec_out_b), .dut_out(dut_out_b),
        .rec_valid(rec_valid_b), .rec_ready(rec_ready_b),
        .rec_vec(rec_vec_b), .rec_resp(rec_resp_b),
        .busy(busy_b), .done(done_b), .resp_ones(resp_ones_b)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    rec_t q_a[$];
    rec_t q_b[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Each accepted record must match the head of the expected queue.
    always @(negedge CK) begin
        rec_t e;
        if (reset && rec_valid_a && rec_ready_a) begin
            checkOutput("a_rec_pending", 32'(q_a.size() > 0), 1);
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                checkOutput("a_rec_vec", 32'(rec_vec_a), 32'(e.v));
                checkOutput("a_rec_resp", 32'(rec_resp_a), 32'(e.r));
            end
        end
    end

    always @(negedge CK) begin
        rec_t e;
        if (reset && rec_valid_b && rec_ready_b) begin
            checkOutput("b_rec_pending", 32'(q_b.size() > 0), 1);
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                checkOutput("b_rec_vec", 32'(rec_vec_b), 32'(e.v));
                checkOutput("b_rec_resp", 32'(rec_resp_b), 32'(e.r));
            end
        end
    end

    task automatic applyStimulus(input bit sel, input bit with_abort, output int t0);
        rec_t r;
        @(posedge CK);
        #1;
        if (sel) begin
            start_b = 1'b1;
            abort_b = with_abort;
        end else begin
            start_a = 1'b1;
            abort_a = with_abort;
        end
        for (int v = 0; v < NVEC; v++) begin
            r.v = 6'(v);
            r.r = sel ? r.v[0] : ^r.v;
            if (sel) q_b.push_back(r);
            else     q_a.push_back(r);
        end
        @(posedge CK);
        #1;
        t0 = cyc;
        start_a = 1'b0;
        abort_a = 1'b0;
        start_b = 1'b0;
        abort_b = 1'b0;
    endtask

    task automatic waitDone(input bit sel, input int t0, input int exp_lat, input string tag);
        bit seen = 1'b0;
        int lat  = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge CK);
            if ((sel ? done_b : done_a) === 1'b1) begin
                seen = 1'b1;
                lat  = cyc - t0;
            end
        end
        checkOutput({tag, "_done_seen"}, 32'(seen), 1);
        if (seen) begin
            checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
            checkOutput({tag, "_busy_in_done"}, 32'(sel ? busy_b : busy_a), 0);
        end
    endtask

    task automatic waitVec(input logic [5:0] value, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge CK);
            if (vec_out_a === value) found = 1'b1;
        end
        checkOutput({tag, "_vec_reached"}, 32'(found), 1);
    endtask

    task automatic watchNoDone(input int cycles, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge CK);
            if (done_a !== 1'b0) seen = 1'b1;
        end
        checkOutput({tag, "_no_done"}, 32'(seen), 0);
    endtask

    initial begin
        int         t0;
        logic [5:0] ten;
        ten         = 6'd10;
        reset       = 1'b0;
        start_a     = 1'b0;
        abort_a     = 1'b0;
        rec_ready_a = 1'b1;
        start_b     = 1'b0;
        abort_b     = 1'b0;
        rec_ready_b = 1'b1;

        repeat (3) @(posedge CK);
        #1;
        checkOutput("rst_vec_out", 32'(vec_out_a), 0);
        checkOutput("rst_rec_valid", 32'(rec_valid_a), 0);
        checkOutput("rst_rec_vec", 32'(rec_vec_a), 0);
        checkOutput("rst_rec_resp", 32'(rec_resp_a), 0);
        checkOutput("rst_busy", 32'(busy_a), 0);
        checkOutput("rst_done", 32'(done_a), 0);
        checkOutput("rst_resp_ones", 32'(resp_ones_a), 0);
        reset = 1'b1;

        // Full parity sweep with the logger always ready.
        applyStimulus(0, 0, t0);
        checkOutput("sweep_busy_after_start", 32'(busy_a), 1);
        waitDone(0, t0, NVEC * 2, "sweep");
        checkOutput("sweep_resp_ones", 32'(resp_ones_a), 32);
        checkOutput("sweep_queue_empty", 32'(q_a.size()), 0);
        @(posedge CK);
        #1;
        checkOutput("sweep_idle_busy", 32'(busy_a), 0);
        checkOutput("sweep_idle_done", 32'(done_a), 0);
        checkOutput("sweep_vec_kept", 32'(vec_out_a), 63);

        // Logger stalls for five cycles while record 10 is presented.
        applyStimulus(0, 0, t0);
        waitVec(6'd10, "stall");
        @(posedge CK);
        #1;
        rec_ready_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CK);
            checkOutput("stall_rec_valid", 32'(rec_valid_a), 1);
            checkOutput("stall_rec_vec", 32'(rec_vec_a), 10);
            checkOutput("stall_rec_resp", 32'(rec_resp_a), 32'(^ten));
            checkOutput("stall_vec_out", 32'(vec_out_a), 10);
            @(posedge CK);
            #1;
        end
        rec_ready_a = 1'b1;
        waitDone(0, t0, NVEC * 2 + 5, "stall");
        checkOutput("stall_queue_empty", 32'(q_a.size()), 0);

        // Longer settle against a DUT with two cycles of latency.
        applyStimulus(1, 0, t0);
        waitDone(1, t0, NVEC * 4, "settle3");
        checkOutput("settle3_resp_ones", 32'(resp_ones_b), 32);
        checkOutput("settle3_queue_empty", 32'(q_b.size()), 0);

        // Abort while vector 20 is settling.
        applyStimulus(0, 0, t0);
        waitVec(6'd20, "abort");
        abort_a = 1'b1;
        @(posedge CK);
        #1;
        abort_a = 1'b0;
        checkOutput("abort_vec_out", 32'(vec_out_a), 0);
        checkOutput("abort_rec_valid", 32'(rec_valid_a), 0);
        checkOutput("abort_busy", 32'(busy_a), 0);
        checkOutput("abort_resp_ones", 32'(resp_ones_a), 10);
        q_a.delete();
        watchNoDone(8, "abort");
        applyStimulus(0, 0, t0);
        waitDone(0, t0, NVEC * 2, "post_abort");
        checkOutput("post_abort_resp_ones", 32'(resp_ones_a), 32);
        checkOutput("post_abort_queue_empty", 32'(q_a.size()), 0);

        // Restart in the cycle after done, with abort raised alongside start.
        applyStimulus(0, 1, t0);
        checkOutput("restart_resp_ones_cleared", 32'(resp_ones_a), 0);
        checkOutput("restart_busy", 32'(busy_a), 1);
        waitDone(0, t0, NVEC * 2, "restart");
        checkOutput("restart_queue_empty", 32'(q_a.size()), 0);

        // Mid-sweep start is ignored; reset mid-sweep clears everything.
        applyStimulus(0, 0, t0);
        waitVec(6'd30, "restart_ignored");
        start_a = 1'b1;
        @(posedge CK);
        #1;
        start_a = 1'b0;
        checkOutput("restart_ignored_vec", 32'(vec_out_a), 30);
        waitVec(6'd40, "midreset");
        reset = 1'b0;
        @(posedge CK);
        #1;
        checkOutput("midreset_vec_out", 32'(vec_out_a), 0);
        checkOutput("midreset_rec_valid", 32'(rec_valid_a), 0);
        checkOutput("midreset_rec_vec", 32'(rec_vec_a), 0);
        checkOutput("midreset_rec_resp", 32'(rec_resp_a), 0);
        checkOutput("midreset_busy", 32'(busy_a), 0);
        checkOutput("midreset_done", 32'(done_a), 0);
        checkOutput("midreset_resp_ones", 32'(resp_ones_a), 0);
        reset = 1'b1;
        q_a.delete();
        watchNoDone(8, "midreset");
        checkOutput("midreset_idle_busy", 32'(busy_a), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
